deint_frame_ctrl: RTL



---
 rtl/deint_frame_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/deint_frame_ctrl.sv
// deint_frame_ctrl: frame-sync acquisition, 4-entry input FIFO and SRAM slot
// multiplexing in front of the deinterleaver address generator.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   din/din_valid/din_sync    input byte stream, sync marks frame byte 0
//   deint_en                  enable to the address generator
//   deint_addr/nwrt/nce       slot address and type from the generator
//   mem_addr/ce_n/we_n/wdata  single-port SRAM request
//   mem_rdata                 SRAM read data, one cycle after a read slot
//   dout/dout_valid/dout_sync deinterleaved output byte stream
//   locked                    high while running
//   err_underrun/overflow/lock one-cycle error pulses
module deint_frame_ctrl #(
    parameter int FRAME_LEN = 1536,
    parameter int MISS_MAX  = 3,
    parameter int WARMUP    = 12288,
    parameter int PRIME_LVL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        din_sync,
    output logic        deint_en,
    input  logic [13:0] deint_addr,
    input  logic        deint_nwrt,
    input  logic        deint_nce,
    output logic [13:0] mem_addr,
    output logic        mem_ce_n,
    output logic        mem_we_n,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        dout_sync,
    output logic        locked,
    output logic        err_underrun,
    output logic        err_overflow,
    output logic        err_lock
);

    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [MW-1:0] MISS_LIM  = MW'(MISS_MAX);
    localparam logic [10:0]   FL_LAST   = 11'(FRAME_LEN - 1);
    localparam logic [13:0]   WARM_LIM  = 14'(WARMUP);
    localparam logic [2:0]    PRIME_CNT = 3'(PRIME_LVL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN
    } state_t;

    state_t      state_q;
    logic [7:0]  fifo_q [4];
    logic [1:0]  wptr_q;
    logic [1:0]  rptr_q;
    logic [2:0]  cnt_q;
    logic [10:0] icnt_q;
    logic [MW-1:0] miss_q;
    logic [13:0] warm_q;
    logic [10:0] ocnt_q;
    logic        rd_pend_q;
    logic        rd_ok_q;
    logic        deint_en_q;
    logic        locked_q;
    logic [7:0]  dout_q;
    logic        dout_valid_q;
    logic        dout_sync_q;
    logic        err_udr_q;
    logic        err_ovf_q;
    logic        err_lck_q;

    logic        idle;
    logic        run;
    logic        wr_slot;
    logic        rd_slot;
    logic        pop;
    logic        udr;
    logic        push_req;
    logic        ovf;
    logic        push;
    logic        frame_pos0;
    logic        lck;
    logic        err_any;
    logic [2:0]  cnt_d;
    logic [10:0] icnt_d;
    logic [MW-1:0] miss_d;

    always_comb begin
        idle     = (state_q == S_IDLE);
        run      = (state_q == S_RUN);
        wr_slot  = run & ~deint_nce & ~deint_nwrt;
        rd_slot  = run & ~deint_nce & deint_nwrt;
        pop      = wr_slot & (cnt_q != 3'd0);
        udr      = wr_slot & (cnt_q == 3'd0);
        // In IDLE only a sync byte is accepted; everything else is dropped.
        push_req = din_valid & (~idle | din_sync);
        ovf      = push_req & (cnt_q == 3'd4) & ~pop;
        push     = push_req & ~ovf;
        cnt_d    = cnt_q + {2'b00, push} - {2'b00, pop};

        icnt_d = icnt_q;
        if (push) begin
            if (idle) begin
                icnt_d = 11'd1;
            end else if (icnt_q == FL_LAST) begin
                icnt_d = '0;
            end else begin
                icnt_d = icnt_q + 11'd1;
            end
        end

        // Sync is only examined on the byte that should start a frame.
        frame_pos0 = push & (idle | (icnt_q == '0));
        miss_d     = miss_q;
        lck        = 1'b0;
        if (frame_pos0) begin
            if (din_sync) begin
                miss_d = '0;
            end else begin
                miss_d = miss_q + MW'(1);
                lck    = (miss_d == MISS_LIM);
            end
        end

        err_any = udr | ovf | lck;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            icnt_q       <= '0;
            miss_q       <= '0;
            warm_q       <= '0;
            ocnt_q       <= '0;
            rd_pend_q    <= 1'b0;
            rd_ok_q      <= 1'b0;
            deint_en_q   <= 1'b0;
            locked_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sync_q  <= 1'b0;
            err_udr_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_lck_q    <= 1'b0;
        end else begin
            err_udr_q <= udr;
            err_ovf_q <= ovf;
            err_lck_q <= lck;

            // rd_ok marks whether this read slot is past the fill depth.
            rd_pend_q <= rd_slot & ~err_any;
            rd_ok_q   <= (warm_q == WARM_LIM);
            if (rd_slot && (warm_q != WARM_LIM)) begin
                warm_q <= warm_q + 14'd1;
            end

            if (rd_pend_q) begin
                dout_q <= mem_rdata;
            end
            dout_valid_q <= rd_pend_q & rd_ok_q;
            dout_sync_q  <= rd_pend_q & rd_ok_q & (ocnt_q == '0);
            if (rd_pend_q && rd_ok_q) begin
                ocnt_q <= (ocnt_q == FL_LAST) ? '0 : ocnt_q + 11'd1;
            end

            if (push) begin
                wptr_q <= wptr_q + 2'd1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
            cnt_q  <= cnt_d;
            icnt_q <= icnt_d;
            miss_q <= miss_d;

            unique case (state_q)
                S_IDLE: begin
                    if (push) begin
                        state_q <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (cnt_d >= PRIME_CNT) begin
                        state_q    <= S_RUN;
                        deint_en_q <= 1'b1;
                        locked_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (err_any) begin
                state_q    <= S_IDLE;
                deint_en_q <= 1'b0;
                locked_q   <= 1'b0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                cnt_q      <= '0;
                icnt_q     <= '0;
                miss_q     <= '0;
                warm_q     <= '0;
                ocnt_q     <= '0;
            end
        end
    end

    assign mem_addr     = deint_addr;
    assign mem_ce_n     = deint_nce;
    assign mem_we_n     = ~pop;
    assign mem_wdata    = fifo_q[rptr_q];
    assign deint_en     = deint_en_q;
    assign locked       = locked_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign dout_sync    = dout_sync_q;
    assign err_underrun = err_udr_q;
    assign err_overflow = err_ovf_q;
    assign err_lock     = err_lck_q;

endmodule
